// File: rtl/nrisc_control_unit.sv
// Multicycle control FSM for the 8-bit Nrisc core: handshaked fetch, decode, sequencing of
// datapath selects, retired-instruction counting and memory-timeout fault detection.
module nrisc_control_unit #(
  parameter int unsigned TIMEOUT = 15,
  parameter int unsigned CNT_W   = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [7:0]       instr,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic [1:0]       pc_src,
  output logic             ir_write,
  output logic             mem_read,
  output logic             mem_write,
  output logic             mem_addr_sel,
  output logic             reg_write,
  output logic             wb_sel,
  output logic [2:0]       alu_op,
  output logic [1:0]       alu_src_b,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] retired,
  output logic             halted,
  output logic             fault
);

  typedef enum logic [2:0] {
    StFetch  = 3'd0,
    StDecode = 3'd1,
    StExec   = 3'd2,
    StMem    = 3'd3,
    StWb     = 3'd4,
    StHalt   = 3'd5
  } state_e;

  localparam logic [3:0] OpOr   = 4'h3;
  localparam logic [3:0] OpAddi = 4'h4;
  localparam logic [3:0] OpLw   = 4'h5;
  localparam logic [3:0] OpSw   = 4'h6;
  localparam logic [3:0] OpBeq  = 4'h7;
  localparam logic [3:0] OpJr   = 4'h8;
  localparam logic [3:0] OpHalt = 4'hF;
  localparam logic [7:0] WaitLast = 8'(TIMEOUT - 1);

  state_e           state_q, state_d;
  logic [7:0]       wait_q;
  logic [CNT_W-1:0] retired_q;
  logic             halted_q, fault_q;
  logic             retire, timeout, waiting, expired;
  logic [3:0]       op;

  assign op = instr[7:4];

  // Register fields are consumed by the datapath, not by the sequencer.
  logic unused_operands;
  assign unused_operands = ^instr[3:0];

  assign waiting = ((state_q == StFetch) || (state_q == StMem)) && !mem_ready;
  assign expired = (wait_q == WaitLast);

  always_comb begin
    state_d = state_q;
    retire  = 1'b0;
    timeout = 1'b0;
    case (state_q)
      StFetch: begin
        if (mem_ready) begin
          state_d = StDecode;
        end else if (expired) begin
          state_d = StHalt;
          timeout = 1'b1;
        end
      end
      StDecode: begin
        if (op == OpHalt) begin
          state_d = StHalt;
          retire  = 1'b1;
        end else if (op > OpJr) begin
          state_d = StFetch;
          retire  = 1'b1;
        end else begin
          state_d = StExec;
        end
      end
      StExec: begin
        if (op <= OpAddi) begin
          state_d = StWb;
        end else if ((op == OpLw) || (op == OpSw)) begin
          state_d = StMem;
        end else begin
          state_d = StFetch;
          retire  = (op == OpBeq) || (op == OpJr);
        end
      end
      StMem: begin
        if (mem_ready) begin
          state_d = (op == OpLw) ? StWb : StFetch;
          retire  = (op != OpLw);
        end else if (expired) begin
          state_d = StHalt;
          timeout = 1'b1;
        end
      end
      StWb: begin
        state_d = StFetch;
        retire  = 1'b1;
      end
      StHalt:  state_d = StHalt;
      default: state_d = StFetch;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= StFetch;
      wait_q    <= '0;
      retired_q <= '0;
      halted_q  <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= waiting ? wait_q + 8'd1 : 8'd0;
      if (retire) begin
        retired_q <= retired_q + CNT_W'(1);
      end
      if (state_d == StHalt) begin
        halted_q <= 1'b1;
      end
      if (timeout) begin
        fault_q <= 1'b1;
      end
    end
  end

  // Strobes are forced low while reset is asserted, whatever state the FSM was left in.
  always_comb begin
    pc_write     = 1'b0;
    pc_src       = 2'd0;
    ir_write     = 1'b0;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    mem_addr_sel = 1'b0;
    reg_write    = 1'b0;
    wb_sel       = 1'b0;
    alu_op       = 3'd0;
    alu_src_b    = 2'd0;
    if (!reset) begin
      case (state_q)
        StFetch: begin
          mem_read = 1'b1;
          if (mem_ready) begin
            ir_write = 1'b1;
            pc_write = 1'b1;
          end
        end
        StExec: begin
          if (op <= OpOr) begin
            alu_op = {1'b0, op[1:0]};
          end else if ((op == OpAddi) || (op == OpLw) || (op == OpSw)) begin
            alu_src_b = 2'd2;
          end else if (op == OpBeq) begin
            alu_op = 3'd1;
            if (zero) begin
              pc_write = 1'b1;
              pc_src   = 2'd1;
            end
          end else if (op == OpJr) begin
            pc_write = 1'b1;
            pc_src   = 2'd2;
          end
        end
        StMem: begin
          mem_addr_sel = 1'b1;
          if (op == OpLw) begin
            mem_read = 1'b1;
          end else begin
            mem_write = 1'b1;
          end
        end
        StWb: begin
          reg_write = 1'b1;
          wb_sel    = (op == OpLw);
        end
        default: ;
      endcase
    end
  end

  assign state   = state_q;
  assign retired = retired_q;
  assign halted  = halted_q;
  assign fault   = fault_q;

endmodule

// File: tb/tb_nrisc_control_unit.sv
// Bench for nrisc_control_unit: vector table, directed corner sequences, and random
// instruction streams checked against a per-instruction phase model.
module tb_nrisc_control_unit;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] instr = 8'h00;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       pc_write, ir_write, mem_read, mem_write, mem_addr_sel, reg_write, wb_sel;
  logic       halted, fault;
  logic [1:0] pc_src, alu_src_b;
  logic [2:0] alu_op, state;
  logic [7:0] retired;

  nrisc_control_unit #(.TIMEOUT(15), .CNT_W(8)) dut (
    .clock(clock), .reset(reset), .instr(instr), .zero(zero), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_src(pc_src), .ir_write(ir_write), .mem_read(mem_read),
    .mem_write(mem_write), .mem_addr_sel(mem_addr_sel), .reg_write(reg_write),
    .wb_sel(wb_sel), .alu_op(alu_op), .alu_src_b(alu_src_b), .state(state),
    .retired(retired), .halted(halted), .fault(fault)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic       pc_write;
    logic [1:0] pc_src;
    logic       ir_write;
    logic       mem_read;
    logic       mem_write;
    logic       mem_addr_sel;
    logic       reg_write;
    logic       wb_sel;
    logic [2:0] alu_op;
    logic [1:0] alu_src_b;
    logic [2:0] state;
  } outs_t;

  typedef struct {
    logic  rdy;
    logic  z;
    outs_t exp;
  } step_t;

  typedef struct {
    logic [7:0] ins;
    logic       z;
    int         cyc;
    logic [7:0] exec;
    int         regw;
    logic       wbs;
  } vec_t;

  logic [16:0] got;
  assign got = {pc_write, pc_src, ir_write, mem_read, mem_write, mem_addr_sel, reg_write,
                wb_sel, alu_op, alu_src_b, state};

  int    tests = 0;
  int    fails = 0;
  step_t steps[$];
  vec_t  tbl[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic outs_t mk(input logic [2:0] st);
    outs_t o;
    o = '0;
    o.state = st;
    return o;
  endfunction

  // Expected cycle-by-cycle phases of one instruction, given fetch and memory wait lengths.
  task automatic build(input logic [7:0] ins, input int fd, input int md);
    int    op;
    step_t s;
    outs_t o;
    op = int'(ins[7:4]);
    steps.delete();
    for (int k = 0; k <= fd; k++) begin
      o = mk(3'd0);
      o.mem_read = 1'b1;
      if (k == fd) begin
        o.ir_write = 1'b1;
        o.pc_write = 1'b1;
      end
      s.rdy = (k == fd);
      s.z   = 1'($urandom);
      s.exp = o;
      steps.push_back(s);
    end
    s.rdy = 1'($urandom);
    s.z   = 1'($urandom);
    s.exp = mk(3'd1);
    steps.push_back(s);
    if (op >= 9) return;
    o     = mk(3'd2);
    s.rdy = 1'($urandom);
    s.z   = 1'($urandom);
    if (op < 4) begin
      o.alu_op = 3'(op);
    end else if (op <= 6) begin
      o.alu_src_b = 2'd2;
    end else if (op == 7) begin
      o.alu_op   = 3'd1;
      o.pc_write = s.z;
      o.pc_src   = s.z ? 2'd1 : 2'd0;
    end else begin
      o.pc_write = 1'b1;
      o.pc_src   = 2'd2;
    end
    s.exp = o;
    steps.push_back(s);
    if (op == 5 || op == 6) begin
      for (int k = 0; k <= md; k++) begin
        o = mk(3'd3);
        o.mem_addr_sel = 1'b1;
        if (op == 5) o.mem_read = 1'b1;
        else         o.mem_write = 1'b1;
        s.rdy = (k == md);
        s.z   = 1'($urandom);
        s.exp = o;
        steps.push_back(s);
      end
    end
    if (op <= 5) begin
      o = mk(3'd4);
      o.reg_write = 1'b1;
      o.wb_sel    = (op == 5);
      s.rdy = 1'($urandom);
      s.z   = 1'($urandom);
      s.exp = o;
      steps.push_back(s);
    end
  endtask

  task automatic play(input string name);
    foreach (steps[i]) begin
      mem_ready = steps[i].rdy;
      zero      = steps[i].z;
      @(negedge clock);
      check(name, 32'(got), 32'(steps[i].exp));
      @(posedge clock);
      #1;
    end
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    mem_ready = 1'b0;
    @(negedge clock);
    check("reset_strobes", 32'(got[16:3]), 32'd0);
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  task automatic measure(input int idx);
    int         cyc;
    int         regw;
    logic [7:0] ex;
    logic       wbs;
    logic [7:0] r0;
    logic [7:0] dr;
    cyc  = 0;
    regw = 0;
    ex   = '0;
    wbs  = 1'b0;
    r0   = retired;
    instr     = tbl[idx].ins;
    zero      = tbl[idx].z;
    mem_ready = 1'b1;
    do begin
      @(negedge clock);
      cyc++;
      if (state == 3'd2) ex = {pc_write, pc_src, alu_op, alu_src_b};
      if (reg_write) begin
        regw++;
        wbs = wb_sel;
      end
      @(posedge clock);
      #1;
    end while (state != 3'd0 && state != 3'd5 && cyc < 20);
    dr = retired - r0;
    check($sformatf("vec%0d_cycles", idx), 32'(cyc), 32'(tbl[idx].cyc));
    check($sformatf("vec%0d_exec", idx), 32'(ex), 32'(tbl[idx].exec));
    check($sformatf("vec%0d_regw", idx), 32'(regw), 32'(tbl[idx].regw));
    check($sformatf("vec%0d_wbsel", idx), 32'(wbs), 32'(tbl[idx].wbs));
    check($sformatf("vec%0d_retired", idx), 32'(dr), 32'd1);
  endtask

  initial begin
    int          op;
    int unsigned model_cnt;

    tbl[0]  = '{8'h49, 1'b0, 4, 8'h02, 1, 1'b0};
    tbl[1]  = '{8'h0B, 1'b0, 4, 8'h00, 1, 1'b0};
    tbl[2]  = '{8'h1B, 1'b0, 4, 8'h04, 1, 1'b0};
    tbl[3]  = '{8'h2B, 1'b0, 4, 8'h08, 1, 1'b0};
    tbl[4]  = '{8'h3B, 1'b0, 4, 8'h0C, 1, 1'b0};
    tbl[5]  = '{8'h56, 1'b0, 5, 8'h02, 1, 1'b1};
    tbl[6]  = '{8'h66, 1'b0, 4, 8'h02, 0, 1'b0};
    tbl[7]  = '{8'h71, 1'b1, 3, 8'hA4, 0, 1'b0};
    tbl[8]  = '{8'h71, 1'b0, 3, 8'h04, 0, 1'b0};
    tbl[9]  = '{8'h84, 1'b0, 3, 8'hC0, 0, 1'b0};
    tbl[10] = '{8'h90, 1'b0, 2, 8'h00, 0, 1'b0};
    tbl[11] = '{8'hE3, 1'b0, 2, 8'h00, 0, 1'b0};

    // Reset state.
    do_reset();
    @(negedge clock);
    check("rst_state", 32'(state), 32'd0);
    check("rst_retired", 32'(retired), 32'd0);
    check("rst_flags", 32'({halted, fault}), 32'd0);
    check("rst_mem_read", 32'(mem_read), 32'd1);
    @(posedge clock);
    #1;

    foreach (tbl[i]) measure(i);

    // LW with three extra memory wait cycles.
    do_reset();
    instr = 8'h56;
    build(8'h56, 0, 3);
    play("lw_wait");
    check("lw_wait_retired", 32'(retired), 32'd1);

    // Fetch timeout.
    do_reset();
    mem_ready = 1'b0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clock);
      check($sformatf("tmo_wait%0d", k), 32'({state, mem_read, fault}), 32'({3'd0, 1'b1, 1'b0}));
      @(posedge clock);
      #1;
    end
    @(negedge clock);
    check("tmo_state", 32'(state), 32'd5);
    check("tmo_flags", 32'({halted, fault}), 32'b11);
    check("tmo_mem_read", 32'(mem_read), 32'd0);
    check("tmo_retired", 32'(retired), 32'd0);
    @(posedge clock);
    #1;

    // HALT instruction, then inputs ignored until reset.
    do_reset();
    instr     = 8'hF0;
    mem_ready = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    @(negedge clock);
    check("halt_state", 32'(state), 32'd5);
    check("halt_flags", 32'({halted, fault}), 32'b10);
    check("halt_retired", 32'(retired), 32'd1);
    for (int k = 0; k < 8; k++) begin
      @(posedge clock);
      #1;
      instr     = 8'($urandom);
      mem_ready = 1'($urandom);
      zero      = 1'($urandom);
      @(negedge clock);
      check("halt_quiet", 32'(got), 32'({14'd0, 3'd5}));
    end
    @(posedge clock);
    #1;
    do_reset();
    @(negedge clock);
    check("halt_reset", 32'({state, halted}), 32'd0);
    @(posedge clock);
    #1;

    // Reset asserted while SW waits in MEM.
    instr     = 8'h66;
    mem_ready = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    mem_ready = 1'b0;
    @(negedge clock);
    check("sw_in_mem", 32'({state, mem_write}), 32'({3'd3, 1'b1}));
    @(posedge clock);
    #1;
    do_reset();
    @(negedge clock);
    check("sw_rst_after", 32'({state, mem_write, mem_read}), 32'({3'd0, 1'b0, 1'b1}));
    @(posedge clock);
    #1;

    // Retired counter wrap via 256 NOPs.
    do_reset();
    instr     = 8'h90;
    mem_ready = 1'b1;
    repeat (510) @(posedge clock);
    #1;
    check("wrap_ff", 32'(retired), 32'hFF);
    repeat (2) @(posedge clock);
    #1;
    check("wrap_00", 32'(retired), 32'h00);
    check("wrap_state", 32'(state), 32'd0);

    // Random instruction stream.
    do_reset();
    model_cnt = 0;
    repeat (150) begin
      op    = int'($urandom_range(0, 14));
      instr = {4'(op), 4'($urandom)};
      build(instr, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
      play("rand_step");
      model_cnt++;
      check("rand_retired", 32'(retired), 32'(model_cnt % 256));
    end
    check("rand_flags", 32'({halted, fault}), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
